regfile_wb_arbiter: RTL

Write-side controller for the 32x64 integer register file. It merges two writeback sources onto the single register-file write port (A3/WD3/WE3):
- the in-order pipeline WB stage, which cannot be back-pressured;
- a long-latency result port (e.g. M-unit divider or memory refill) with a valid/ready handshake.

A FIFO buffers long-latency results. A pending-write scoreboard is exported to the hazard unit.

---
 rtl/regfile_wb_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Merges pipeline WB and long-latency results onto the register-file write
// port, with a result FIFO and a pending-write scoreboard.
// Optional : `define WB_STATS_EN adds saturating write/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_valid,
    input  logic [4:0]                    pipe_rd,
    input  logic [XLEN-1:0]               pipe_wd,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [4:0]                    lu_rd,
    input  logic [XLEN-1:0]               lu_wd,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic [31:0]                   busy,
    output logic                          stall_req,
    output logic                          rf_we,
    output logic [4:0]                    rf_a3,
    output logic [XLEN-1:0]               rf_wd,
`ifdef WB_STATS_EN
    output logic [CNT_W-1:0]              stat_pipe_wr,
    output logic [CNT_W-1:0]              stat_lu_wr,
    output logic [CNT_W-1:0]              stat_stall,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_FULL = c_OCC_W'(FIFO_DEPTH);

    logic [4:0]         r_mem_rd [FIFO_DEPTH];
    logic [XLEN-1:0]    r_mem_wd [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_OCC_W-1:0] r_count;
    logic               r_stall_req;
    logic [31:0]        r_busy;
    logic               r_rf_we;
    logic [4:0]         r_rf_a3;
    logic [XLEN-1:0]    r_rf_wd;

    logic               w_push;
    logic               w_pop;
    logic               w_sel_pipe;
    logic [4:0]         w_head_rd;
    logic [XLEN-1:0]    w_head_wd;
    logic [c_OCC_W-1:0] w_count_next;
    logic [31:0]        w_busy_next;

    assign lu_ready     = (r_count != c_FULL);
    assign w_push       = lu_valid && lu_ready;
    assign w_sel_pipe   = pipe_valid && (pipe_rd != 5'd0);
    // A pipe write to x0 is a no-op, so it does not block a FIFO pop.
    assign w_pop        = !w_sel_pipe && (r_count != '0);
    assign w_head_rd    = r_mem_rd[r_rptr];
    assign w_head_wd    = r_mem_wd[r_rptr];
    assign w_count_next = r_count + c_OCC_W'(w_push) - c_OCC_W'(w_pop);

    always_comb begin
        w_busy_next = r_busy;
        if (w_pop && (w_head_rd != 5'd0))
            w_busy_next[w_head_rd] = 1'b0;
        // Set after clear so a same-edge issue wins.
        if (issue_valid && (issue_rd != 5'd0))
            w_busy_next[issue_rd] = 1'b1;
    end

    // Storage has no reset; validity is tracked solely by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr] <= lu_rd;
            r_mem_wd[r_wptr] <= lu_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_stall_req <= 1'b0;
            r_busy      <= '0;
            r_rf_we     <= 1'b0;
            r_rf_a3     <= '0;
            r_rf_wd     <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count     <= w_count_next;
            r_stall_req <= (w_count_next == c_FULL);
            r_busy      <= w_busy_next;
            if (w_sel_pipe) begin
                r_rf_we <= 1'b1;
                r_rf_a3 <= pipe_rd;
                r_rf_wd <= pipe_wd;
            end else if (w_pop) begin
                r_rf_we <= (w_head_rd != 5'd0);
                r_rf_a3 <= w_head_rd;
                r_rf_wd <= w_head_wd;
            end else begin
                r_rf_we <= 1'b0;
            end
        end
    end

    assign busy       = r_busy;
    assign stall_req  = r_stall_req;
    assign rf_we      = r_rf_we;
    assign rf_a3      = r_rf_a3;
    assign rf_wd      = r_rf_wd;
    assign fifo_count = r_count;

`ifdef WB_STATS_EN
    logic [CNT_W-1:0] r_stat_pipe_wr;
    logic [CNT_W-1:0] r_stat_lu_wr;
    logic [CNT_W-1:0] r_stat_stall;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pipe_wr <= '0;
            r_stat_lu_wr   <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_sel_pipe && (r_stat_pipe_wr != '1))
                r_stat_pipe_wr <= r_stat_pipe_wr + 1'b1;
            if (w_pop && (w_head_rd != 5'd0) && (r_stat_lu_wr != '1))
                r_stat_lu_wr <= r_stat_lu_wr + 1'b1;
            if (r_stall_req && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_pipe_wr = r_stat_pipe_wr;
    assign stat_lu_wr   = r_stat_lu_wr;
    assign stat_stall   = r_stat_stall;
`endif

`ifndef SYNTHESIS
    a_issue_to_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_valid && (issue_rd != 5'd0) && r_busy[issue_rd] &&
          !(w_pop && (w_head_rd == issue_rd))));
`endif

endmodule

`default_nettype wire
